// File: rtl/dm_bytelane.sv
// Byte-lane data memory for the MIPS MEM stage: load/store with lane merge, extension and error reporting.
// Optional store trace is enabled by defining DM_TRACE_EN.
module dm_bytelane #(
  parameter int DEPTH = 3072,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic        ready,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata
);

  typedef enum logic {INIT, RUN} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] clr_idx;
  logic [31:0]      mem [DEPTH];

  logic             accept;
  logic             in_range;
  logic             misaligned;
  logic             bad;
  logic [IDX_W-1:0] widx;
  logic [31:0]      rd_word;
  logic [31:0]      merged;

  function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] wd,
                                             input logic [1:0] sz, input logic [1:0] off);
    logic [31:0] res;
    res = old;
    case (sz)
      2'b00:   res[{off, 3'b000} +: 8] = wd[7:0];
      2'b01:   res[{off[1], 4'b0000} +: 16] = wd[15:0];
      default: res = wd;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] sz,
                                           input logic [1:0] off, input logic sx);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (sz)
      2'b00:   res = {{24{sx & b[7]}}, b};
      2'b01:   res = {{16{sx & h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  assign ready      = (state == RUN);
  assign accept     = req && ready;
  // Full 30-bit word index is compared so out-of-range addresses never alias.
  assign in_range   = {2'b00, addr[31:2]} < 32'(DEPTH);
  assign misaligned = (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
  assign bad        = !in_range || misaligned || (size == 2'b11);
  assign widx       = addr[IDX_W+1:2];
  assign rd_word    = mem[widx];
  assign merged     = lane_merge(rd_word, wdata, size, addr[1:0]);

  always_comb begin
    state_nxt = state;
    if (state == INIT && clr_idx == IDX_W'(DEPTH - 1)) state_nxt = RUN;
  end

  // Control and response registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= INIT;
      clr_idx <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) clr_idx <= clr_idx + 1'b1;
      done <= accept;
      if (accept) begin
        err   <= bad;
        rdata <= (bad || we) ? 32'd0 : load_ext(rd_word, size, addr[1:0], sign_ext);
      end else begin
        err <= 1'b0;
      end
    end
  end

  // Array write port: sweep clear during INIT, merged stores during RUN
  always_ff @(posedge clk) begin
    if (state == INIT)
      mem[clr_idx] <= '0;
    else if (accept && we && !bad)
      mem[widx] <= merged;
  end

`ifdef DM_TRACE_EN
  always_ff @(posedge clk) begin
    if (reset && accept && we && !bad)
      $display("%d@%h: *%h <= %h", $time, pc, {addr[31:2], 2'b00}, merged);
  end
`else
  logic unused_pc;
  assign unused_pc = ^pc;
`endif

endmodule

// File: tb/tb_dm_bytelane.sv
// Bench for dm_bytelane: byte-array reference model compared every cycle, plus directed literal checks.
module tb_dm_bytelane;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sign_ext = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] pc = '0;
  logic        ready, done, err;
  logic [31:0] rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dm_bytelane #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .pc(pc), .ready(ready), .done(done), .err(err), .rdata(rdata)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: memory as a flat byte array, responses from the access rules.
  logic [7:0]  mm [DEPTH*4];
  int          swp = 0;
  logic        e_ready = 1'b0, e_done = 1'b0, e_err = 1'b0;
  logic [31:0] e_rdata = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      swp = 0; e_ready = 1'b0; e_done = 1'b0; e_err = 1'b0; e_rdata = '0;
    end else if (!e_ready) begin
      e_done = 1'b0;
      swp++;
      if (swp == DEPTH) begin
        foreach (mm[i]) mm[i] = 8'h00;
        e_ready = 1'b1;
      end
    end else if (req) begin
      int nb;
      logic bad_acc;
      logic [31:0] v;
      nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      bad_acc = (size == 2'd3) || (addr % nb != 0) || (addr >= 32'(DEPTH*4));
      e_done = 1'b1;
      if (bad_acc) begin
        e_err = 1'b1; e_rdata = '0;
      end else if (we) begin
        for (int b = 0; b < nb; b++) mm[addr + b] = wdata[8*b +: 8];
        e_err = 1'b0; e_rdata = '0;
      end else begin
        v = '0;
        for (int b = 0; b < nb; b++) v |= 32'(mm[addr + b]) << (8*b);
        if (sign_ext && nb < 4 && v[8*nb-1]) v |= ~((32'd1 << (8*nb)) - 32'd1);
        e_err = 1'b0; e_rdata = v;
      end
    end else begin
      e_done = 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("ready", {31'd0, ready}, {31'd0, e_ready});
    chk("done", {31'd0, done}, {31'd0, e_done});
    if (e_done) chk("err", {31'd0, err}, {31'd0, e_err});
    chk("rdata", rdata, e_rdata);
  end

  task automatic acc(input logic w, input logic [1:0] sz, input logic sx, input logic [31:0] a,
                     input logic [31:0] d, output logic [31:0] r, output logic e);
    int n;
    n = 0;
    req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = d;
    while (!ready && n < 64) begin @(negedge clk); n++; end
    chk("acc_ready", {31'd0, ready}, 32'd1);
    @(negedge clk);
    req = 1'b0;
    r = rdata; e = err;
    chk("acc_done", {31'd0, done}, 32'd1);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!ready && n < 64) begin @(negedge clk); n++; end
    chk("wait_ready", {31'd0, ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] r;
    logic        e;

    #1;
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      @(negedge clk);
      chk("sweep_edge", {31'd0, ready}, {31'd0, i == DEPTH});
    end

    // fill every word, then reset and confirm the sweep wiped it
    for (int w = 0; w < DEPTH; w++) acc(1'b1, 2'd2, 1'b0, 32'(w*4), 32'hA5000000 | 32'(w), r, e);
    acc(1'b0, 2'd2, 1'b0, 32'h1C, '0, r, e);
    chk("fill_rd", r, 32'hA5000007);
    @(posedge clk); #2 reset = 1'b0;
    #1 chk("rst2_ready", {31'd0, ready}, 32'd0);
    @(negedge clk); reset = 1'b1;
    wait_ready();
    for (int w = 0; w < DEPTH; w++) begin
      acc(1'b0, 2'd2, 1'b0, 32'(w*4), '0, r, e);
      chk("swept_zero", r, 32'd0);
      chk("swept_err", {31'd0, e}, 32'd0);
    end

    acc(1'b1, 2'd2, 1'b0, 32'h8, 32'h12345678, r, e);
    acc(1'b0, 2'd0, 1'b1, 32'h9, '0, r, e);  chk("lb9s", r, 32'h00000056);
    acc(1'b0, 2'd0, 1'b0, 32'hB, '0, r, e);  chk("lbB", r, 32'h00000012);
    acc(1'b0, 2'd1, 1'b1, 32'hA, '0, r, e);  chk("lhAs", r, 32'h00001234);
    acc(1'b1, 2'd0, 1'b0, 32'h8, 32'h80, r, e);
    acc(1'b0, 2'd0, 1'b1, 32'h8, '0, r, e);  chk("lb8s", r, 32'hFFFFFF80);
    acc(1'b0, 2'd0, 1'b0, 32'h8, '0, r, e);  chk("lb8u", r, 32'h00000080);
    acc(1'b0, 2'd2, 1'b0, 32'h8, '0, r, e);  chk("lw8", r, 32'h12345680);

    acc(1'b0, 2'd2, 1'b0, 32'h6, '0, r, e);
    chk("lw6_err", {31'd0, e}, 32'd1); chk("lw6_rdata", r, 32'd0);
    acc(1'b1, 2'd1, 1'b0, 32'h5, 32'hBEEF, r, e); chk("sh5_err", {31'd0, e}, 32'd1);
    acc(1'b0, 2'd2, 1'b0, 32'h4, '0, r, e);  chk("lw4_same", r, 32'd0);
    acc(1'b0, 2'd3, 1'b0, 32'h0, '0, r, e);  chk("size3_err", {31'd0, e}, 32'd1);
    acc(1'b1, 2'd2, 1'b0, 32'h40, 32'hDEADBEEF, r, e); chk("range_err", {31'd0, e}, 32'd1);
    acc(1'b0, 2'd2, 1'b0, 32'h0, '0, r, e);  chk("nowrap", r, 32'd0);

    // store then load on consecutive edges
    pc = 32'h00003000;
    req = 1'b1; we = 1'b1; size = 2'd0; sign_ext = 1'b0; addr = 32'h5; wdata = 32'hA5;
    @(negedge clk); we = 1'b0;
    @(negedge clk); req = 1'b0;
    chk("b2b_done", {31'd0, done}, 32'd1);
    chk("b2b_rdata", rdata, 32'h000000A5);

    // reset with a load response pending, then reset mid-sweep at clr_idx 7
    acc(1'b1, 2'd2, 1'b0, 32'h20, 32'hCAFEF00D, r, e);
    req = 1'b1; we = 1'b0; size = 2'd2; addr = 32'h20;
    @(posedge clk); #2 reset = 1'b0; req = 1'b0;
    #1 chk("mid_done", {31'd0, done}, 32'd0);
    chk("mid_ready", {31'd0, ready}, 32'd0);
    @(negedge clk); reset = 1'b1;
    repeat (7) @(posedge clk);
    #2 reset = 1'b0;
    #1 chk("sweep7_ready", {31'd0, ready}, 32'd0);
    @(negedge clk); reset = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      @(negedge clk);
      chk("resweep_edge", {31'd0, ready}, {31'd0, i == DEPTH});
    end
    acc(1'b0, 2'd2, 1'b0, 32'h20, '0, r, e); chk("post_rst_zero", r, 32'd0);

    // randomized traffic, checked by the model every cycle
    repeat (800) begin
      @(negedge clk);
      req      = ($urandom_range(0, 3) != 0);
      we       = 1'($urandom_range(0, 1));
      size     = 2'($urandom_range(0, 3));
      sign_ext = 1'($urandom_range(0, 1));
      addr     = 32'($urandom_range(0, 71));
      if ($urandom_range(0, 2) != 0) addr[1:0] = (size == 2'd2) ? 2'b00 : (size == 2'd1) ? {addr[1], 1'b0} : addr[1:0];
      wdata    = $urandom;
      pc       = $urandom;
    end
    @(negedge clk); req = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dm_bytelane.md
# dm_bytelane

Parametrised single-port data memory for the pipelined MIPS core's MEM stage, with byte, halfword and word accesses. Each access is a request/response pair.
- Stores merge into the addressed byte lanes.
- Loads return a registered, sign- or zero-extended result one cycle after acceptance.
- Misaligned and out-of-range accesses raise an error instead of corrupting memory.
- After reset, a hardware sweep clears the array one word per cycle; the block refuses requests until the sweep finishes.

## Interface
- DEPTH, 3072: number of 32-bit words. Any integer ≥ 2, not necessarily a power of two.
- IDX_W, $clog2(DEPTH): word-index width (derived; do not override).

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req  in  1  access request; held by the requester until accepted
- we  in  1  1 = store, 0 = load
- size  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal
- sign_ext  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- addr  in  32  byte address
- wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- pc  in  32  PC of the requesting instruction (trace only)
- ready  out  1  block can accept a request this cycle
- done  out  1  one-cycle pulse, one cycle after each accepted request
- err  out  1  valid with done; access was misaligned, out of range or illegal size
- rdata  out  32  load result, valid with done

## Operation
- States: INIT (clearing sweep) and RUN.
- Reset asserted (reset=0), asynchronously:
  - state=INIT, clr_idx=0;
  - ready=0, done=0, err=0, rdata=0.
- INIT:
  - Each clock edge writes 0 to mem[clr_idx], then clr_idx increments.
  - On the edge that clears word DEPTH-1, state goes to RUN.
  - req is ignored; nothing is latched or queued.
- RUN: ready=1. A request is accepted on any edge where req=1 and ready=1. Back-to-back acceptance every cycle is allowed.
- Word index: addr[31:2]. The access is out of range if addr[31:2] ≥ DEPTH. The full 30-bit index is compared, so there is no aliasing or wrap.
- Misaligned access:
  - size=01 with addr[0]=1;
  - size=10 with addr[1:0]≠0.
- Error case (out of range, misaligned, or size=11):
  - no array write;
  - done=1, err=1, rdata=0 on the next cycle.
- Store:
  - byte writes lane addr[1:0] with wdata[7:0];
  - half writes lanes {addr[1],0}+1:{addr[1],0} with wdata[15:0];
  - word writes all lanes;
  - other lanes are unchanged.
  - Response: done=1, err=0, rdata=0.
- Load:
  - rdata gets the selected lane(s), extended to 32 bits per sign_ext;
  - word loads ignore sign_ext.
  - Response: done=1, err=0.
- Read-after-write: a store accepted at edge k is visible to a load accepted at edge k+1.
- Reset mid-sweep or mid-operation: the sweep restarts at word 0. A pending done is dropped.

## Timing
- Reset release to ready: DEPTH rising edges.
  - Edges 1..DEPTH clear words 0..DEPTH-1.
  - ready goes high after edge DEPTH.
- Latency: request accepted at edge k gives done/err/rdata valid from after edge k until edge k+1.
- done is low in every cycle that follows an edge with no accepted request. rdata holds its last value while done=0.
- Throughput: one access per cycle in RUN.
- ready is purely a function of state (no combinational path from req).

## Configuration
- DM_TRACE_EN defined:
  - Every accepted, error-free store prints `$display("%d@%h: *%h <= %h", $time, pc, {addr[31:2],2'b00}, merged_word)`.
  - merged_word is the full 32-bit word after lane merge.
  - Errored accesses print nothing.
- DM_TRACE_EN undefined: no simulation output. Logic is otherwise identical.

## Test plan
All scenarios use DEPTH=16.
- Sweep: pre-fill the array via hierarchical force, then pulse reset. Required:
  - ready=0 for 16 edges, ready=1 after edge 16;
  - lw of 0x00..0x3C all return 0x00000000, err=0.
- Lanes:
  - sw 0x12345678 at 0x8;
  - lb 0x9 signed → 0x00000056;
  - lb 0xB → 0x00000012;
  - lh 0xA signed → 0x00001234;
  - sb 0x80 at 0x8, then lb 0x8 signed → 0xFFFFFF80, unsigned → 0x00000080;
  - lw 0x8 → 0x12345680.
- Errors:
  - lw 0x6 → done=1, err=1, rdata=0;
  - sh 0x5 with 0xBEEF → err=1, lw 0x4 is unchanged;
  - size=11 → err=1.
- Range: sw 0xDEADBEEF at 0x40 → err=1; lw 0x0 is still 0x00000000 (no wrap).
- Reset mid-operation:
  - assert reset while clr_idx=7 → ready/done drop immediately, sweep restarts at 0 and takes 16 edges;
  - a word written before the reset reads 0 afterwards.
- Pipelined/trace:
  - back-to-back sw 0xA5 (sb) at 0x5 then lb 0x5 unsigned on consecutive edges → 0x000000A5;
  - with DM_TRACE_EN and pc=0x00003000, one line showing *00000004 <= 0000a500.
